beatmap_sequencer: RTL and testbench
====================================

Name: beatmap_sequencer

Overview:
Upstream feeder for the beatmap ping-pong RAM controller. Walks a synchronous beatmap ROM at a fixed tempo and emits one 8-bit note byte per beat on a data_en/data interface. Expands run-length rest counts into empty beats. Stops on an end marker.

Parameters:
ADDR_W, 8, ROM address width; addresses 0..2^ADDR_W-1
CLKS_PER_BEAT, 12500000, clk cycles per beat tick; must be ≥4
DIV_W, 24, beat divider width; must satisfy 2^DIV_W > CLKS_PER_BEAT

Ports:
clk  in  1  system clock
resetn  in  1  synchronous, active-low reset
start  in  1  1-cycle pulse; begins playback from address 0
pause  in  1  level; freezes beat divider and tick consumption
rom_rd_en  out  1  ROM read strobe
rom_addr  out  ADDR_W  ROM read address
rom_data  in  8  ROM data, valid the cycle after rom_rd_en
data_en  out  1  note byte valid
data  out  8  note byte {4'h0, lane_mask}; 8'h00 = empty beat
out_ready  in  1  downstream accepts when data_en && out_ready
busy  out  1  high from start acceptance until DONE/IDLE
done  out  1  sticky; high after end of map, cleared by start
overrun  out  1  sticky; beat lost, cleared by start

Behaviour:
- Interface: reset resetn, synchronous, active-low; clock clk.
- Reset value of every output is 0. Reset enters IDLE.
- Reset mid-operation aborts playback, clears the divider and the pending flag, and returns to IDLE with all outputs 0.
- ROM byte format:
  - [3:0] lane_mask.
  - [7:4] rest count R. R = 0..14 means emit the mask beat, then R beats of 8'h00.
  - [7:4] == 4'hF is the end marker. Nothing is emitted for it.
- States: IDLE, FETCH, WAIT, ARMED, EMIT, REST, DONE.
- Transitions:
  - IDLE/DONE: start -> FETCH. This clears rom_addr, done, overrun and the divider. start is ignored in any other state.
  - FETCH: rom_rd_en=1 for one cycle -> WAIT.
  - WAIT: latch rom_data.
    - End marker -> DONE (done=1, busy=0).
    - Otherwise -> ARMED.
  - ARMED: on a beat tick (or a pending tick), present data={4'h0,mask} with data_en=1 from the next cycle; rest_cnt<=R; -> EMIT.
  - EMIT: hold data and data_en stable until accepted.
    - On accept with rest_cnt>0 -> REST.
    - On accept with rest_cnt==0 -> rom_addr+1 and -> FETCH.
  - REST: on a tick, present 8'h00 valid and decrement rest_cnt. After acceptance:
    - rest_cnt==0 -> advance the address and -> FETCH.
    - else stay in REST.
- Beat divider: counts only while busy and !pause. Tick when count==CLKS_PER_BEAT-1, then the count wraps to 0. The first tick comes CLKS_PER_BEAT cycles after start acceptance.
- Tick during FETCH/WAIT sets a pending flag. The flag is consumed on entry to ARMED, which emits immediately.
- Overrun cases: a tick while data_en is unaccepted, or a tick while pending is already set. In either case set overrun=1 and drop the tick. Beats are never queued.
- Latency: start accepted in cycle 0 -> rom_rd_en in cycle 1 -> byte latched end of cycle 2 -> data_en the cycle after the first tick.
- Address wrap: accept at address 2^ADDR_W-1 with no end marker is treated as an end marker.
- pause does not block acceptance of an already-presented byte.

Optional Feature:
BEATMAP_LOOP_EN
- Defined: on an end marker or address wrap, rom_addr<=0 and -> FETCH. busy stays high and done is never set. Exception: if the byte at address 0 is itself an end marker, -> DONE (prevents a livelock).
- Undefined: behaviour as above (-> DONE).

Decomposition:
- beatmap_pkg holds:
  - state encoding
  - END_NIBBLE=4'hF
  - field positions MASK_LSB=0, REST_LSB=4
  - EMPTY_BEAT=8'h00
- Sub-module beat_tick_gen: divider with clear, enable and a 1-cycle tick output.

Test Plan:
All tests use CLKS_PER_BEAT=8.
- Basic playback. ROM {8'h21, 8'h04, 8'hF0}, out_ready=1, start -> data 8'h01, 8'h00, 8'h00, 8'h04, with data_en pulses exactly 8 cycles apart and the first at cycle 9 after start. Then done=1, busy=0.
- Backpressure. ROM {8'h05, 8'h06, 8'hF0}, out_ready=0 for 20 cycles after the first data_en -> data holds 8'h05 stable, overrun=1. After out_ready=1, the next byte emitted is 8'h06.
- Pause. ROM {8'h13, 8'hF0}, pause high for 20 cycles right after 8'h03 is accepted -> the 8'h00 emission is delayed by exactly 20 cycles. overrun stays 0.
- Loop (BEATMAP_LOOP_EN).
  - ROM {8'h03, 8'hF0} -> 8'h03 every 8 cycles indefinitely, done=0.
  - ROM {8'hF0} -> done=1 after one fetch, no data_en.
- Reset mid-run. resetn=0 for 1 cycle during REST -> next cycle all outputs 0. A new start refetches address 0.
- Start while busy. start while busy -> ignored: rom_addr sequence and emitted bytes are unchanged.

Source files
------------

// File: rtl/beatmap_pkg.sv
// Shared types and constants for the beatmap sequencer: FSM encoding and ROM byte layout.
package beatmap_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_ARMED,
        S_EMIT,
        S_REST,
        S_DONE
    } state_t;

    localparam logic [3:0] END_NIBBLE = 4'hF;
    localparam int         MASK_LSB   = 0;
    localparam int         REST_LSB   = 4;
    localparam logic [7:0] EMPTY_BEAT = 8'h00;

    // Extracts one 4-bit field of a ROM byte.
    function automatic logic [3:0] field4(input logic [7:0] b, input int lsb);
        return b[lsb +: 4];
    endfunction

endpackage

// File: rtl/beat_tick_gen.sv
// Beat divider: counts enabled cycles and pulses tick for one cycle every CLKS_PER_BEAT of them.
module beat_tick_gen #(
    parameter int CLKS_PER_BEAT = 12500000,
    parameter int DIV_W         = 24
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam logic [DIV_W-1:0] LAST = DIV_W'(CLKS_PER_BEAT - 1);

    logic [DIV_W-1:0] count_q, count_d;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        count_d = count_q;
        tick    = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            if (count_q == LAST) begin
                count_d = '0;
                tick    = 1'b1;
            end else begin
                count_d = count_q + DIV_W'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) count_q <= '0;
        else         count_q <= count_d;
    end

endmodule

// File: rtl/beatmap_sequencer.sv
// Walks a beatmap ROM at a fixed tempo, emitting one note byte per beat and expanding rest counts.
// Define BEATMAP_LOOP_EN to restart from address 0 at the end of the map instead of stopping.
module beatmap_sequencer
    import beatmap_pkg::*;
#(
    parameter int ADDR_W        = 8,
    parameter int CLKS_PER_BEAT = 12500000,
    parameter int DIV_W         = 24
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              pause,
    output logic              rom_rd_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic              data_en,
    output logic [7:0]        data,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        byte_q, byte_d;
    logic [3:0]        rest_cnt_q, rest_cnt_d;
    logic [7:0]        data_q, data_d;
    logic              data_en_q, data_en_d;
    logic              pending_q, pending_d;
    logic              done_q, done_d;
    logic              overrun_q, overrun_d;

    logic start_ok, tick, accept, beat, go_next, go_done;

    assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
    assign start_ok = start && !busy;
    assign accept   = data_en_q && out_ready;
    assign beat     = !pause && (tick || pending_q);

    beat_tick_gen #(
        .CLKS_PER_BEAT(CLKS_PER_BEAT),
        .DIV_W        (DIV_W)
    ) u_tick (
        .clk   (clk),
        .resetn(resetn),
        .clr   (start_ok),
        .en    (busy && !pause),
        .tick  (tick)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        byte_d     = byte_q;
        rest_cnt_d = rest_cnt_q;
        data_d     = data_q;
        data_en_d  = data_en_q;
        pending_d  = pending_q;
        done_d     = done_q;
        overrun_d  = overrun_q;
        go_next    = 1'b0;
        go_done    = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    addr_d    = '0;
                    done_d    = 1'b0;
                    overrun_d = 1'b0;
                    pending_d = 1'b0;
                    state_d   = S_FETCH;
                end
            end
            S_FETCH, S_WAIT: begin
                // A beat landing mid-fetch is remembered once; a second one is lost.
                if (tick) begin
                    if (pending_q) overrun_d = 1'b1;
                    else           pending_d = 1'b1;
                end
                if (state_q == S_FETCH) begin
                    state_d = S_WAIT;
                end else begin
                    byte_d = rom_data;
                    if (field4(rom_data, REST_LSB) == END_NIBBLE) begin
`ifdef BEATMAP_LOOP_EN
                        if (addr_q == '0) begin
                            go_done = 1'b1;
                        end else begin
                            addr_d  = '0;
                            state_d = S_FETCH;
                        end
`else
                        go_done = 1'b1;
`endif
                    end else begin
                        state_d = S_ARMED;
                    end
                end
            end
            S_ARMED: begin
                if (beat) begin
                    data_d     = {4'h0, field4(byte_q, MASK_LSB)};
                    data_en_d  = 1'b1;
                    rest_cnt_d = field4(byte_q, REST_LSB);
                    pending_d  = 1'b0;
                    if (tick && pending_q) overrun_d = 1'b1;
                    state_d    = S_EMIT;
                end
            end
            S_EMIT, S_REST: begin
                if (data_en_q) begin
                    if (accept) begin
                        data_en_d = 1'b0;
                        // A tick coinciding with acceptance belongs to the next beat.
                        if (tick) pending_d = 1'b1;
                        if (rest_cnt_q != 4'd0) state_d = S_REST;
                        else                    go_next = 1'b1;
                    end else if (tick) begin
                        overrun_d = 1'b1;
                    end
                end else if (beat) begin
                    data_d     = EMPTY_BEAT;
                    data_en_d  = 1'b1;
                    rest_cnt_d = rest_cnt_q - 4'd1;
                    pending_d  = 1'b0;
                    if (tick && pending_q) overrun_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (go_next) begin
            if (addr_q == '1) begin
`ifdef BEATMAP_LOOP_EN
                addr_d  = '0;
                state_d = S_FETCH;
`else
                go_done = 1'b1;
`endif
            end else begin
                addr_d  = addr_q + ADDR_W'(1);
                state_d = S_FETCH;
            end
        end
        if (go_done) begin
            state_d   = S_DONE;
            done_d    = 1'b1;
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            byte_q     <= '0;
            rest_cnt_q <= '0;
            data_q     <= '0;
            data_en_q  <= 1'b0;
            pending_q  <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            byte_q     <= byte_d;
            rest_cnt_q <= rest_cnt_d;
            data_q     <= data_d;
            data_en_q  <= data_en_d;
            pending_q  <= pending_d;
            done_q     <= done_d;
            overrun_q  <= overrun_d;
        end
    end

    assign rom_rd_en = (state_q == S_FETCH);
    assign rom_addr  = addr_q;
    assign data_en   = data_en_q;
    assign data      = data_q;
    assign done      = done_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_beatmap_sequencer.sv
// Directed bench for beatmap_sequencer at 8 clocks per beat; cycle numbers count from the start cycle.
module tb_beatmap_sequencer;

    localparam int ADDR_W = 8;
    localparam int CPB    = 8;
    localparam int DIV_W  = 4;

    logic              clk       = 1'b0;
    logic              resetn    = 1'b0;
    logic              start     = 1'b0;
    logic              pause     = 1'b0;
    logic              out_ready = 1'b1;
    logic              rom_rd_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_data  = 8'h00;
    logic              data_en;
    logic [7:0]        data;
    logic              busy, done, overrun;

    logic [7:0] rom [256];
    int cyc = 0;
    int t0  = 0;
    int checks = 0;
    int failures = 0;
    int beat_data[$];
    int beat_cyc[$];
    int fetch_addr[$];

    always #5 clk = ~clk;

    beatmap_sequencer #(
        .ADDR_W       (ADDR_W),
        .CLKS_PER_BEAT(CPB),
        .DIV_W        (DIV_W)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .start    (start),
        .pause    (pause),
        .rom_rd_en(rom_rd_en),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .data_en  (data_en),
        .data     (data),
        .out_ready(out_ready),
        .busy     (busy),
        .done     (done),
        .overrun  (overrun)
    );

    // Synchronous ROM model and free-running cycle counter.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rom_rd_en) rom_data <= rom[rom_addr];
    end

    // Record accepted beats and ROM fetch addresses, sampled mid-cycle.
    always @(negedge clk) begin
        if (data_en && out_ready) begin
            beat_data.push_back(int'(data));
            beat_cyc.push_back(cyc - t0);
        end
        if (rom_rd_en) fetch_addr.push_back(int'(rom_addr));
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 8'hF0;
    endtask

    task automatic clear_logs();
        beat_data.delete();
        beat_cyc.delete();
        fetch_addr.delete();
    endtask

    task automatic reset_dut();
        step(1);
        resetn    = 1'b0;
        start     = 1'b0;
        pause     = 1'b0;
        out_ready = 1'b1;
        step(2);
        resetn = 1'b1;
        step(1);
        clear_logs();
    endtask

    task automatic do_start();
        start = 1'b1;
        t0    = cyc;
        step(1);
        start = 1'b0;
    endtask

    task automatic check_beat(input string tag, input int idx, input int exp_d, input int exp_c);
        check({tag, "_present"}, (beat_data.size() > idx) ? 1 : 0, 1);
        if (beat_data.size() > idx) begin
            check({tag, "_data"}, beat_data[idx], exp_d);
            check({tag, "_cycle"}, beat_cyc[idx], exp_c);
        end
    endtask

    task automatic check_fetch(input string tag, input int idx, input int exp_a);
        check({tag, "_present"}, (fetch_addr.size() > idx) ? 1 : 0, 1);
        if (fetch_addr.size() > idx) check({tag, "_addr"}, fetch_addr[idx], exp_a);
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {rom_rd_en, rom_addr, data_en, data, busy, done, overrun}, '0);
    endtask

    initial begin
        // Reset state.
        clear_rom();
        reset_dut();
        check_all_zero("reset_outputs");

        // Basic playback: 01, two rests, 04, then end marker.
        clear_rom();
        rom[0] = 8'h21; rom[1] = 8'h04; rom[2] = 8'hF0;
        do_start();
        step(44);
        check("basic_nbeats", beat_data.size(), 4);
        check_beat("basic_b0", 0, 8'h01, 9);
        check_beat("basic_b1", 1, 8'h00, 17);
        check_beat("basic_b2", 2, 8'h00, 25);
        check_beat("basic_b3", 3, 8'h04, 33);
        check("basic_done", done, 1);
        check("basic_busy", busy, 0);
        check("basic_overrun", overrun, 0);
        check("basic_nfetch", fetch_addr.size(), 3);
        check_fetch("basic_f2", 2, 2);

        // Backpressure: byte held for 20 cycles, ticks meanwhile are lost.
        reset_dut();
        clear_rom();
        rom[0] = 8'h05; rom[1] = 8'h06; rom[2] = 8'hF0;
        out_ready = 1'b0;
        do_start();
        step(8);
        begin
            logic hold_ok;
            hold_ok = 1'b1;
            for (int i = 0; i < 20; i++) begin
                if (!(data_en === 1'b1 && data === 8'h05)) hold_ok = 1'b0;
                step(1);
            end
            check("bp_hold_stable", hold_ok, 1);
        end
        check("bp_overrun", overrun, 1);
        out_ready = 1'b1;
        step(30);
        check("bp_nbeats", beat_data.size(), 2);
        check_beat("bp_b0", 0, 8'h05, 29);
        check_beat("bp_b1", 1, 8'h06, 33);
        check("bp_done", done, 1);

        // Pause for 20 cycles right after the mask beat is accepted.
        reset_dut();
        clear_rom();
        rom[0] = 8'h13; rom[1] = 8'hF0;
        do_start();
        step(9);
        pause = 1'b1;
        step(20);
        check("pause_busy_held", busy, 1);
        pause = 1'b0;
        step(20);
        check("pause_nbeats", beat_data.size(), 2);
        check_beat("pause_b0", 0, 8'h03, 9);
        check_beat("pause_b1", 1, 8'h00, 37);
        check("pause_overrun", overrun, 0);
        check("pause_done", done, 1);

        // End marker at address 0: finishes with no beats in either build.
        reset_dut();
        clear_rom();
        do_start();
        step(10);
        check("empty_done", done, 1);
        check("empty_busy", busy, 0);
        check("empty_nbeats", beat_data.size(), 0);
        check("empty_nfetch", fetch_addr.size(), 1);

        // Single note followed by end marker.
        reset_dut();
        clear_rom();
        rom[0] = 8'h03; rom[1] = 8'hF0;
        do_start();
        step(38);
`ifdef BEATMAP_LOOP_EN
        check("loop_nbeats", beat_data.size(), 4);
        check_beat("loop_b0", 0, 8'h03, 9);
        check_beat("loop_b1", 1, 8'h03, 17);
        check_beat("loop_b3", 3, 8'h03, 33);
        check("loop_done", done, 0);
        check("loop_busy", busy, 1);
`else
        check("once_nbeats", beat_data.size(), 1);
        check_beat("once_b0", 0, 8'h03, 9);
        check("once_done", done, 1);
        check("once_busy", busy, 0);
`endif

        // Reset in REST of the second byte, then replay from address 0.
        reset_dut();
        clear_rom();
        rom[0] = 8'h04; rom[1] = 8'h21; rom[2] = 8'hF0;
        do_start();
        step(19);
        check("rst_pre_busy", busy, 1);
        check("rst_pre_addr", rom_addr, 1);
        check("rst_pre_data", data, 8'h01);
        resetn = 1'b0;
        step(1);
        check_all_zero("rst_mid_outputs");
        resetn = 1'b1;
        step(1);
        clear_logs();
        do_start();
        step(11);
        check_fetch("rst_refetch", 0, 0);
        check_beat("rst_b0", 0, 8'h04, 9);

        // Start pulses while busy change nothing.
        reset_dut();
        clear_rom();
        rom[0] = 8'h21; rom[1] = 8'h04; rom[2] = 8'hF0;
        do_start();
        step(4);
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(14);
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(24);
        check("busy_start_nbeats", beat_data.size(), 4);
        check_beat("busy_start_b0", 0, 8'h01, 9);
        check_beat("busy_start_b2", 2, 8'h00, 25);
        check_beat("busy_start_b3", 3, 8'h04, 33);
        check("busy_start_nfetch", fetch_addr.size(), 3);
        check_fetch("busy_start_f0", 0, 0);
        check_fetch("busy_start_f1", 1, 1);
        check("busy_start_done", done, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
